// File: rtl/game_pkg.sv
// Shared types and constants for the whack-a-mole game sequencer.
// Holds the FSM state encoding, LFSR taps and the mole pattern helper.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SPAWN,
    HOLD,
    DONE
  } state_e;

  localparam int NUM_MOLES = 5;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  // An all-zero pattern would leave nothing to hit, so force one mole.
  function automatic logic [NUM_MOLES-1:0] mole_pattern(
    input logic [15:0] s
  );
    logic [NUM_MOLES-1:0] p;
    p = s[NUM_MOLES-1:0];
    mole_pattern = (p == '0) ? NUM_MOLES'(1) : p;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit right-shifting Galois LFSR with enable.
// A zero seed would lock up, so it is replaced by the default seed.
module lfsr16
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;
  logic [15:0] rst_val;

  assign rst_val = (seed == 16'h0) ? LFSR_DEFAULT_SEED : seed;

  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = {1'b0, q_q[15:1]} ^ (q_q[0] ? LFSR_TAPS : 16'h0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= rst_val;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/mole_spawner.sv
// Game sequencer: loads a random mole pattern each round, holds it
// for a timed window (or until cleared), then flags game over.
module mole_spawner
  import game_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned NUM_ROUNDS  = 20,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter bit          EARLY_CLEAR = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NUM_MOLES-1:0] board_state,
  output logic                 load,
  output logic [NUM_MOLES-1:0] loadval,
  output logic [7:0]           round_cnt,
  output logic                 game_over
);

  if (NUM_ROUNDS < 1 || NUM_ROUNDS > 255) begin : g_bad_rounds
    $error("mole_spawner: NUM_ROUNDS must be 1..255");
  end
  if (HOLD_CYCLES < 2) begin : g_bad_hold
    $error("mole_spawner: HOLD_CYCLES must be >= 2");
  end

  localparam logic [31:0] HOLD_LAST = 32'(HOLD_CYCLES - 1);
  localparam logic [7:0]  ROUNDS    = 8'(NUM_ROUNDS);

  state_e               state_q, state_d;
  logic [31:0]          timer_q, timer_d;
  logic [7:0]           round_q, round_d;
  logic                 load_q, load_d;
  logic [NUM_MOLES-1:0] loadval_q, loadval_d;
  logic                 over_q, over_d;
  logic [15:0]          lfsr;
  logic                 lfsr_en;
  logic                 first_hold;
  logic                 cleared;
  logic                 hold_exit;

  assign lfsr_en = (state_q == IDLE && !start) || state_q == SPAWN;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (lfsr_en),
    .seed  (LFSR_SEED),
    .q     (lfsr)
  );

  // Timer is at its reload value only in the first HOLD cycle.
  assign first_hold = (timer_q == HOLD_LAST);
  assign cleared    = EARLY_CLEAR && board_state == '0 && !first_hold;
  assign hold_exit  = (timer_q == 32'd0) || cleared;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    round_d   = round_q;
    load_d    = 1'b0;
    loadval_d = '0;
    over_d    = over_q;
    unique case (1'b1)
      (state_q == IDLE || state_q == DONE): begin
        if (start) begin
          state_d   = SPAWN;
          load_d    = 1'b1;
          loadval_d = mole_pattern(lfsr);
          round_d   = 8'd1;
          over_d    = 1'b0;
        end
      end
      (state_q == SPAWN): begin
        state_d = HOLD;
        timer_d = HOLD_LAST;
      end
      (state_q == HOLD): begin
        if (!hold_exit) begin
          timer_d = timer_q - 32'd1;
        end else if (round_q == ROUNDS) begin
          state_d = DONE;
          over_d  = 1'b1;
        end else begin
          state_d   = SPAWN;
          load_d    = 1'b1;
          loadval_d = mole_pattern(lfsr);
          round_d   = round_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      round_q   <= '0;
      load_q    <= 1'b0;
      loadval_q <= '0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      round_q   <= round_d;
      load_q    <= load_d;
      loadval_q <= loadval_d;
      over_q    <= over_d;
    end
  end

  assign load      = load_q;
  assign loadval   = loadval_q;
  assign round_cnt = round_q;
  assign game_over = over_q;

endmodule

// File: tb/tb_mole_spawner.sv
// Bench for mole_spawner: three instances (default, zero-pattern seed,
// no early clear) checked against a round/gap/LFSR reference model.
module tb_mole_spawner;
  import game_pkg::*;

  localparam int H  = 4;
  localparam int NR = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n[3];
  logic       start[3];
  logic [4:0] board[3];
  logic       load[3];
  logic [4:0] loadval[3];
  logic [7:0] round_cnt[3];
  logic       game_over[3];

  logic [15:0] lref[3];
  int n_tests = 0;
  int n_fail  = 0;

  mole_spawner #(
    .HOLD_CYCLES(H), .NUM_ROUNDS(NR),
    .LFSR_SEED(16'hACE1), .EARLY_CLEAR(1'b1)
  ) u_a (
    .clk(clk), .rst_n(rst_n[0]), .start(start[0]),
    .board_state(board[0]), .load(load[0]),
    .loadval(loadval[0]), .round_cnt(round_cnt[0]),
    .game_over(game_over[0])
  );

  mole_spawner #(
    .HOLD_CYCLES(H), .NUM_ROUNDS(NR),
    .LFSR_SEED(16'h0020), .EARLY_CLEAR(1'b1)
  ) u_b (
    .clk(clk), .rst_n(rst_n[1]), .start(start[1]),
    .board_state(board[1]), .load(load[1]),
    .loadval(loadval[1]), .round_cnt(round_cnt[1]),
    .game_over(game_over[1])
  );

  mole_spawner #(
    .HOLD_CYCLES(H), .NUM_ROUNDS(NR),
    .LFSR_SEED(16'hACE1), .EARLY_CLEAR(1'b0)
  ) u_c (
    .clk(clk), .rst_n(rst_n[2]), .start(start[2]),
    .board_state(board[2]), .load(load[2]),
    .loadval(loadval[2]), .round_cnt(round_cnt[2]),
    .game_over(game_over[2])
  );

  function automatic logic [15:0] lnext(input logic [15:0] x);
    logic [15:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ 16'hB400;
    return y;
  endfunction

  function automatic logic [4:0] pat(input logic [15:0] x);
    logic [4:0] p;
    p = x[4:0];
    if (p == 5'd0) p = 5'd1;
    return p;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input int d);
    chk("rst_load", load[d], 0);
    chk("rst_loadval", loadval[d], 0);
    chk("rst_round", round_cnt[d], 0);
    chk("rst_over", game_over[d], 0);
  endtask

  // IDLE with start low: LFSR advances once per edge.
  task automatic idle_wait(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      chk("idle_load", load[d], 0);
      lref[d] = lnext(lref[d]);
    end
  endtask

  task automatic check_load(input int d, input int k);
    chk("load_pulse", load[d], 1);
    chk("load_round", round_cnt[d], k);
    chk("load_val", loadval[d], pat(lref[d]));
    chk("load_over", game_over[d], 0);
    lref[d] = lnext(lref[d]);
  endtask

  // One full game; expected gap between loads comes from the clear point.
  task automatic run_game(input int d, input bit ec,
                          input bit rnd, input bit hold_start);
    int m;
    int gap;
    start[d] = 1'b1;
    cyc();
    if (!hold_start) start[d] = 1'b0;
    for (int k = 1; k <= NR; k++) begin
      check_load(d, k);
      m = rnd ? int'($urandom_range(0, H)) : 0;
      gap = (ec && m > 0) ? ((m < 2) ? 2 : m) + 1 : H + 1;
      board[d] = 5'h1f;
      for (int j = 1; j < gap; j++) begin
        cyc();
        chk("hold_load", load[d], 0);
        chk("hold_loadval", loadval[d], 0);
        chk("hold_round", round_cnt[d], k);
        if (!rnd)
          board[d] = 5'h1f;
        else if (m == 0)
          board[d] = (j == 1) ? 5'h0 : 5'($urandom_range(1, 31));
        else
          board[d] = (j >= m) ? 5'h0 : 5'($urandom_range(1, 31));
      end
      cyc();
    end
    chk("done_over", game_over[d], 1);
    chk("done_load", load[d], 0);
    chk("done_round", round_cnt[d], NR);
  endtask

  task automatic finish_game(input int d, input int k0);
    int k;
    bit done;
    k = k0;
    done = 1'b0;
    board[d] = 5'h1f;
    for (int c = 0; c < 200 && !done; c++) begin
      cyc();
      if (load[d]) begin
        k++;
        chk("fin_round", round_cnt[d], k);
        chk("fin_loadval", loadval[d], pat(lref[d]));
        lref[d] = lnext(lref[d]);
      end
      if (game_over[d]) done = 1'b1;
    end
    chk("fin_done", done, 1);
    chk("fin_rounds", k, NR);
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0;
      start[i] = 1'b0;
      board[i] = 5'h1f;
    end
    lref[0] = 16'hACE1;
    lref[1] = 16'h0020;
    lref[2] = 16'hACE1;

    #3;
    chk_reset(0);
    cyc();
    cyc();
    chk_reset(0);
    rst_n[0] = 1'b1;
    idle_wait(0, 20);

    run_game(0, 1'b1, 1'b0, 1'b0);

    run_game(0, 1'b1, 1'b1, 1'b1);
    cyc();
    check_load(0, 1);
    start[0] = 1'b0;
    finish_game(0, 1);

    start[0] = 1'b1;
    cyc();
    start[0] = 1'b0;
    check_load(0, 1);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      cyc();
      if (load[0]) begin
        check_load(0, 2);
        seen = 1'b1;
      end
    end
    chk("round2_seen", seen, 1);
    cyc();
    cyc();
    #2 rst_n[0] = 1'b0;
    #1 chk_reset(0);
    cyc();
    chk_reset(0);
    rst_n[0] = 1'b1;
    lref[0] = 16'hACE1;
    idle_wait(0, 10);
    run_game(0, 1'b1, 1'b1, 1'b0);
    for (int g = 0; g < 4; g++) run_game(0, 1'b1, 1'b1, 1'b0);

    cyc();
    rst_n[1] = 1'b1;
    run_game(1, 1'b1, 1'b1, 1'b0);
    run_game(1, 1'b1, 1'b1, 1'b0);

    cyc();
    rst_n[2] = 1'b1;
    idle_wait(2, 3);
    run_game(2, 1'b0, 1'b1, 1'b0);
    run_game(2, 1'b0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
